mux_scan_collector: RTL and testbench
=====================================

// Module: mux_scan_collector
// PURPOSE
//   Scan sequencer and collector for the 4:1 if-else mux stage.
//   - Drives the mux select lines through every input, waiting a configurable settle time on each.
//   - Samples the mux output once per input and packs the samples into one parallel word.
//   - Presents the word through a valid/ready handshake; sits directly around the mux (drives sel, consumes y).
// PARAMETERS
//   SEL_W   2  select width; number of scanned inputs N = 2**SEL_W
//   DWELL   1  wait cycles after each sel change before sampling y (0 allowed: sample on next edge)
// PORTS
//   clk       in   1          single clock, all logic on posedge
//   rst       in   1          synchronous, active-high reset
//   start     in   1          request one scan; sampled only in IDLE
//   y_in      in   1          mux output being sampled
//   sel       out  SEL_W      mux select; registered
//   data_out  out  2**SEL_W   collected word; bit i = y_in sampled while sel==i
//   valid     out  1          data_out holds a complete scan
//   ready     in   1          downstream accepts data_out when valid&&ready at posedge
//   busy      out  1          1 whenever state != IDLE
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state=IDLE, sel=0, data_out=0, valid=0, busy=0, dwell count=0.
//   - Reset mid-scan or mid-DONE: partial or undelivered data discarded; all outputs take reset values next cycle.
//   - FSM states:
//     - IDLE: start=1 -> SCAN, sel=0, cnt=DWELL.
//     - SCAN, cnt!=0: cnt--.
//     - SCAN, cnt==0: data_out[sel]<=y_in; if sel==N-1 -> DONE with valid=1; else sel++, cnt=DWELL.
//     - DONE: valid=1 and data_out held stable; valid&&ready -> IDLE, valid=0, sel=0.
//   - Latency: valid rises N*(DWELL+1) posedges after the edge that accepts start (N=4, DWELL=1: 8 cycles).
//   - y_in is sampled only at capture edges; glitches on y_in during dwell cycles are ignored.
//   - start is ignored in SCAN and DONE; no queueing.
//     - start held high continuously: a new scan begins the cycle after returning to IDLE.
//   - ready is ignored unless valid=1. ready held high: DONE lasts exactly 1 cycle.
//   - Backpressure: DONE persists indefinitely while ready=0; sel stays at N-1.
//   - data_out bits from the previous scan stay visible until overwritten; the word is meaningful only while valid=1.
//   - sel wraps only via explicit reload to 0; it never increments past N-1.
//   - Dwell counter width is max(1, $clog2(DWELL+1)).
// CONFIGURATION
//   SCAN_CONTINUOUS_EN
//     - Defined: in DONE, valid&&ready -> SCAN directly with sel=0, cnt=DWELL, valid=0 (free-running after the first start; only rst returns to IDLE).
//     - Back-to-back scans have no idle gap: next valid arrives N*(DWELL+1) cycles after the accepting edge.
//     - Not defined: every scan needs a fresh start in IDLE (behaviour above).
// STRUCTURE
//   - mux_scan_pkg: state typedef (IDLE/SCAN/DONE, 2-bit encoding) and default SEL_W/DWELL localparams.
//   - Sub-module scan_dwell_cnt: loadable down-counter.
//     - Inputs: load, load value, enable.
//     - Output: zero flag.
//     - Instantiated once.
//   - Everything else is in the top FSM.
// TESTING (DUT wired to the 4:1 mux, SEL_W=2, DWELL=1 unless noted)
//   1. Basic scan: a=4'b1010, 1-cycle start pulse, ready=1 -> sel steps 0,1,2,3 every 2 cycles;
//      valid=1 on 8th edge with data_out=4'b1010; next cycle valid=0, busy=0.
//   2. Backpressure: a=4'b0110, ready=0 for 5 cycles after valid -> data_out=4'b0110 stable and valid=1 throughout;
//      the ready pulse clears valid next edge.
//   3. Ignored start: a=4'b1111, extra start pulses during SCAN and DONE -> exactly one valid with 4'b1111, then IDLE.
//   4. Reset mid-scan: rst=1 when sel==2 -> next cycle sel=0, valid=0, busy=0, data_out=0;
//      a new start with a=4'b0001 returns 4'b0001.
//   5. DWELL=0: a=4'b1001 -> sel changes every cycle; valid on 4th edge with 4'b1001.
//   6. SCAN_CONTINUOUS_EN, ready=1, a changed 4'b1010 -> 4'b0101 mid-run
//      -> consecutive words with valid every 9 cycles (8 scan + 1 DONE), each matching a at its capture edges.

Source files
------------

// File: rtl/mux_scan_pkg.sv
// Shared types and defaults for the mux scan collector.
// Holds the FSM state encoding and the default SEL_W/DWELL values.
package mux_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int SEL_W_DEF = 2;
    localparam int DWELL_DEF = 1;

    // Dwell counter width: max(1, clog2(dwell+1)).
    function automatic int cnt_w(input int dwell);
        if ($clog2(dwell + 1) < 1) return 1;
        return $clog2(dwell + 1);
    endfunction

endpackage

// File: rtl/scan_dwell_cnt.sv
// Loadable down-counter that times the settle period after each sel change.
// Ports: clk, rst (sync, active-high), load_i, load_val_i, en_i -> zero_o.
module scan_dwell_cnt #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Load has priority; decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_collector.sv
// Scan sequencer/collector around a 2**SEL_W:1 mux: steps sel, samples y_in, packs a word.
// Ports: clk, rst, start, y_in, ready in; sel, data_out, valid, busy out. Option: SCAN_CONTINUOUS_EN.
module mux_scan_collector
    import mux_scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DWELL = DWELL_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  y_in,
    output logic [SEL_W-1:0]      sel,
    output logic [2**SEL_W-1:0]   data_out,
    output logic                  valid,
    input  logic                  ready,
    output logic                  busy
);

    localparam int N  = 2**SEL_W;
    localparam int CW = cnt_w(DWELL);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(N - 1);
    localparam logic [CW-1:0]    DWELL_V  = CW'(DWELL);

    state_e           state_q;
    state_e           state_d;
    logic [SEL_W-1:0] sel_q;
    logic [SEL_W-1:0] sel_d;
    logic [N-1:0]     data_q;
    logic [N-1:0]     data_d;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_zero;

    scan_dwell_cnt #(
        .W (CW)
    ) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .load_val_i (DWELL_V),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    assign cnt_en = (state_q == ST_SCAN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        data_d   = data_q;
        cnt_load = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_SCAN;
                    sel_d    = '0;
                    cnt_load = 1'b1;
                end
            end
            ST_SCAN: begin
                // Capture edge: settle time elapsed for the current sel.
                if (cnt_zero) begin
                    data_d[sel_q] = y_in;
                    if (sel_q == SEL_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d    = sel_q + 1'b1;
                        cnt_load = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (ready) begin
                    sel_d = '0;
`ifdef SCAN_CONTINUOUS_EN
                    state_d  = ST_SCAN;
                    cnt_load = 1'b1;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        valid = (state_q == ST_DONE);
        busy  = (state_q != ST_IDLE);
    end

    assign sel      = sel_q;
    assign data_out = data_q;

endmodule

// File: tb/tb_mux_scan_collector.sv
// Randomized scoreboard bench for mux_scan_collector (DWELL=0 and DWELL=1 instances).
// Honours SCAN_CONTINUOUS_EN when defined for the build.
module tb_mux_scan_collector;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ready;
  logic [3:0] a;
  int         nchk = 0;
  int         nfail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int D = g;

    logic [1:0] sel_w;
    logic [3:0] dout_w;
    logic       valid_w;
    logic       busy_w;
    logic       y_w;
    logic       gmask = 1'b0;

    int         mst = 0;
    int         t = 0;
    logic [1:0] msel = 2'd0;
    logic [3:0] mdata = 4'd0;
    logic [3:0] q[$];
    logic       vprev = 1'b0;

    assign y_w = a[sel_w] ^ gmask;

    mux_scan_collector #(
      .SEL_W (2),
      .DWELL (D)
    ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .y_in     (y_w),
      .sel      (sel_w),
      .data_out (dout_w),
      .valid    (valid_w),
      .ready    (ready),
      .busy     (busy_w)
    );

    task automatic check(input string n,
                         input logic [31:0] act,
                         input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
        nfail++;
        $display("FAIL dwell%0d %s got=%0h exp=%0h t=%0t",
                 D, n, act, exp, $time);
      end
    endtask

    always @(posedge clk) begin
      int k;
      if (rst) begin
        mst   = 0;
        t     = 0;
        msel  = 2'd0;
        mdata = 4'd0;
      end else begin
        case (mst)
          0: if (start) begin
            mst  = 1;
            t    = 0;
            msel = 2'd0;
          end
          1: begin
            if (((t + 1) % (D + 1)) == 0) begin
              k = (t + 1) / (D + 1) - 1;
              mdata[k] = a[k];
              if (k == 3) begin
                mst = 2;
                q.push_back(mdata);
              end
            end
            t++;
            msel = 2'((t / (D + 1)) > 3 ? 3 : t / (D + 1));
          end
          default: if (ready) begin
            msel = 2'd0;
`ifdef SCAN_CONTINUOUS_EN
            mst = 1;
            t   = 0;
`else
            mst = 0;
`endif
          end
        endcase
      end
    end

    always @(negedge clk) begin
      logic capn;
      capn  = (mst == 1) && (((t + 1) % (D + 1)) == 0);
      gmask = ($urandom_range(0, 3) == 0) && !capn;
    end

    always @(negedge clk) begin
      logic [3:0] e;
      check("valid", 32'(valid_w), 32'(mst == 2));
      check("busy", 32'(busy_w), 32'(mst != 0));
      check("sel", 32'(sel_w), 32'(msel));
      check("data", 32'(dout_w), 32'(mdata));
      if (valid_w && !vprev) begin
        if (q.size() == 0) begin
          nchk++;
          nfail++;
          $display("FAIL dwell%0d word_unexpected got=%0h exp=none",
                   D, dout_w);
        end else begin
          e = q.pop_front();
          check("word", 32'(dout_w), 32'(e));
        end
      end
      check("pending", 32'(q.size()), 32'd0);
      vprev = valid_w;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    a     = 4'b0000;
    cyc(3);
    rst = 1'b0;
    cyc(2);

    a = 4'b1010; ready = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(14);

    a = 4'b0110; ready = 1'b0; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(20);
    ready = 1'b1;
    cyc(1);
    ready = 1'b0;
    cyc(3);

    a = 4'b1111; ready = 1'b1; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(3);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(12);

    a = 4'b0110; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(4);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(2);
    a = 4'b0001; start = 1'b1;
    cyc(1);
    start = 1'b0;
    cyc(14);

    a = 4'b1010; start = 1'b1; ready = 1'b1;
    cyc(13);
    a = 4'b0101;
    cyc(25);
    start = 1'b0;
    cyc(12);

    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      rst   = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 4) == 0) a = 4'($urandom);
      cyc(1);
    end
    rst   = 1'b0;
    start = 1'b0;
    ready = 1'b1;
    cyc(12);

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
